// File: rtl/id_stage_if.sv
// Fetch, write-back and ID/EX signals of the decode stage, bundled for port connection.
// The slave modport is the decode stage; the master modport is its surroundings.
interface id_stage_if #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 8
);
    logic                     if_valid;
    logic [31:0]              if_instr;
    logic [PC_W-1:0]          if_pc;
    logic                     flush;
    logic                     wb_we;
    logic [4:0]               wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     stall;
    logic                     id_ex_valid;
    logic [PC_W-1:0]          id_ex_pc;
    logic [5:0]               id_ex_op;
    logic signed [DATA_W-1:0] id_ex_rs_data;
    logic signed [DATA_W-1:0] id_ex_rt_data;
    logic signed [DATA_W-1:0] id_ex_imm;
    logic [4:0]               id_ex_dest;
    logic                     id_ex_reg_write;
    logic                     id_ex_mem_read;
    logic                     id_ex_mem_write;

    modport master (
        output if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data,
        input  stall, id_ex_valid, id_ex_pc, id_ex_op, id_ex_rs_data, id_ex_rt_data,
               id_ex_imm, id_ex_dest, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data,
        output stall, id_ex_valid, id_ex_pc, id_ex_op, id_ex_rs_data, id_ex_rt_data,
               id_ex_imm, id_ex_dest, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, 32-entry register file with write-through
// bypass, load-use hazard detection and the registered ID/EX bundle.
module id_stage #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.slave   bus
);
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h10;
    localparam logic [5:0] OP_LD   = 6'h20;
    localparam logic [5:0] OP_ST   = 6'h21;

    typedef struct packed {
        logic                     valid;
        logic [PC_W-1:0]          pc;
        logic [5:0]               op;
        logic signed [DATA_W-1:0] rs_data;
        logic signed [DATA_W-1:0] rt_data;
        logic signed [DATA_W-1:0] imm;
        logic [4:0]               dest;
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
    } id_ex_t;

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    // r0 is hard-wired zero; a same-cycle write to the read index is forwarded.
    function automatic logic signed [DATA_W-1:0] read_port(
        input logic [4:0]        idx,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [4:0]        waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (idx == 5'd0)
            return '0;
        else if (we && (waddr == idx))
            return wdata;
        else
            return stored;
    endfunction

    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_d [32];
    id_ex_t            idex_q, idex_d;

    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       reads_rs, reads_rt;
    logic       dec_reg_write, dec_mem_read, dec_mem_write;
    logic [4:0] dec_dest;
    logic       stall;

    assign op = ifid_instr_q[31:26];
    assign rs = ifid_instr_q[25:21];
    assign rt = ifid_instr_q[20:16];
    assign rd = ifid_instr_q[15:11];

    always_comb begin
        reads_rs      = 1'b0;
        reads_rt      = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_dest      = 5'd0;
        case (op)
            OP_ADD, OP_SUB: begin
                reads_rs = 1'b1; reads_rt = 1'b1; dec_reg_write = 1'b1; dec_dest = rd;
            end
            OP_ADDI: begin
                reads_rs = 1'b1; dec_reg_write = 1'b1; dec_dest = rt;
            end
            OP_LD: begin
                reads_rs = 1'b1; dec_reg_write = 1'b1; dec_mem_read = 1'b1; dec_dest = rt;
            end
            OP_ST: begin
                reads_rs = 1'b1; reads_rt = 1'b1; dec_mem_write = 1'b1;
            end
            default: ;
        endcase
    end

    // A load in EX whose destination feeds the instruction in ID holds fetch for one cycle.
    always_comb begin
        stall = 1'b0;
        if (!bus.flush && ifid_valid_q && idex_q.valid && idex_q.mem_read && (idex_q.dest != 5'd0))
            stall = (reads_rs && (idex_q.dest == rs)) || (reads_rt && (idex_q.dest == rt));
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (bus.flush) begin
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            ifid_valid_d = bus.if_valid;
            ifid_instr_d = bus.if_instr;
            ifid_pc_d    = bus.if_pc;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (bus.wb_we && (bus.wb_addr != 5'd0))
            rf_d[bus.wb_addr] = bus.wb_data;
    end

    // Data fields always load the current decode; only valid and controls are squashed.
    always_comb begin
        idex_d.valid     = ifid_valid_q;
        idex_d.pc        = ifid_pc_q;
        idex_d.op        = op;
        idex_d.rs_data   = read_port(rs, rf_q[rs], bus.wb_we, bus.wb_addr, bus.wb_data);
        idex_d.rt_data   = read_port(rt, rf_q[rt], bus.wb_we, bus.wb_addr, bus.wb_data);
        idex_d.imm       = sext16(ifid_instr_q[15:0]);
        idex_d.dest      = dec_dest;
        idex_d.reg_write = ifid_valid_q && dec_reg_write;
        idex_d.mem_read  = ifid_valid_q && dec_mem_read;
        idex_d.mem_write = ifid_valid_q && dec_mem_write;
        if (bus.flush || stall) begin
            idex_d.valid     = 1'b0;
            idex_d.reg_write = 1'b0;
            idex_d.mem_read  = 1'b0;
            idex_d.mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            idex_q       <= '0;
            rf_q         <= '{default: '0};
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            idex_q       <= idex_d;
            rf_q         <= rf_d;
        end
    end

    assign bus.stall           = stall;
    assign bus.id_ex_valid     = idex_q.valid;
    assign bus.id_ex_pc        = idex_q.pc;
    assign bus.id_ex_op        = idex_q.op;
    assign bus.id_ex_rs_data   = idex_q.rs_data;
    assign bus.id_ex_rt_data   = idex_q.rt_data;
    assign bus.id_ex_imm       = idex_q.imm;
    assign bus.id_ex_dest      = idex_q.dest;
    assign bus.id_ex_reg_write = idex_q.reg_write;
    assign bus.id_ex_mem_read  = idex_q.mem_read;
    assign bus.id_ex_mem_write = idex_q.mem_write;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, bypass, load-use stall and flush.
module tb_id_stage;
    localparam int DATA_W = 64;
    localparam int PC_W   = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    id_stage #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [7:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [63:0] d);
        bus.wb_we   = we;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        bus.flush = 1'b0;
        rst = 1'b1;
        present(rtype(6'h01, 5'd1, 5'd2, 5'd3), 8'h55);
        wb(1'b1, 5'd3, 64'hDEAD);
        @(negedge clk);
        tick();
        rst = 1'b0;
        idle();
        wb(1'b0, 5'd0, '0);
        check("rst_valid", bus.id_ex_valid, 1'b0);
        check("rst_pc", bus.id_ex_pc, 8'h00);
        check("rst_op", bus.id_ex_op, 6'h00);
        check("rst_rs", bus.id_ex_rs_data, 64'd0);
        check("rst_imm", bus.id_ex_imm, 64'd0);
        check("rst_dest", bus.id_ex_dest, 5'd0);
        check("rst_ctrl", {bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write}, 3'b000);
        check("rst_stall", bus.stall, 1'b0);

        // Preload r1=5, r2=7
        wb(1'b1, 5'd1, 64'd5); tick();
        wb(1'b1, 5'd2, 64'd7); tick();
        wb(1'b0, 5'd0, '0);

        // ADD r3,r1,r2: two edges to outputs
        present(rtype(6'h01, 5'd1, 5'd2, 5'd3), 8'h10); tick();
        idle(); tick();
        check("add_valid", bus.id_ex_valid, 1'b1);
        check("add_pc", bus.id_ex_pc, 8'h10);
        check("add_op", bus.id_ex_op, 6'h01);
        check("add_rs", bus.id_ex_rs_data, 64'd5);
        check("add_rt", bus.id_ex_rt_data, 64'd7);
        check("add_dest", bus.id_ex_dest, 5'd3);
        check("add_ctrl", {bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write}, 3'b100);

        // r3 write during reset was lost
        present(rtype(6'h01, 5'd3, 5'd0, 5'd4), 8'h11); tick();
        idle(); tick();
        check("rst_r3", bus.id_ex_rs_data, 64'd0);

        // Bypass: write r1 while ADD reading r1 sits in IF/ID
        present(rtype(6'h02, 5'd1, 5'd2, 5'd6), 8'h12); tick();
        idle(); wb(1'b1, 5'd1, 64'h99); tick();
        wb(1'b0, 5'd0, '0);
        check("byp_rs", bus.id_ex_rs_data, 64'h99);
        check("byp_rt", bus.id_ex_rt_data, 64'd7);
        check("sub_op", bus.id_ex_op, 6'h02);

        // r0 writes ignored, including same-cycle bypass
        present(rtype(6'h01, 5'd0, 5'd0, 5'd7), 8'h13); wb(1'b1, 5'd0, 64'h55); tick();
        idle(); wb(1'b1, 5'd0, 64'h66); tick();
        wb(1'b0, 5'd0, '0);
        check("r0_rs", bus.id_ex_rs_data, 64'd0);
        check("r0_rt", bus.id_ex_rt_data, 64'd0);

        // Load-use: LD r4,0(r1) then ADD r5,r4,r2
        present(itype(6'h20, 5'd1, 5'd4, 16'd0), 8'h20); tick();
        present(rtype(6'h01, 5'd4, 5'd2, 5'd5), 8'h21);
        check("lu_nostall_early", bus.stall, 1'b0);
        tick();
        check("lu_stall", bus.stall, 1'b1);
        check("ld_ctrl", {bus.id_ex_valid, bus.id_ex_mem_read, bus.id_ex_reg_write}, 3'b111);
        check("ld_dest", bus.id_ex_dest, 5'd4);
        tick();
        check("lu_bubble", bus.id_ex_valid, 1'b0);
        check("lu_bubble_ctrl", {bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write}, 3'b000);
        check("lu_stall_once", bus.stall, 1'b0);
        idle(); tick();
        check("lu_add_valid", bus.id_ex_valid, 1'b1);
        check("lu_add_pc", bus.id_ex_pc, 8'h21);
        check("lu_add_dest", bus.id_ex_dest, 5'd5);
        check("lu_add_rt", bus.id_ex_rt_data, 64'd7);

        // LD r4 then ADDI r5,r6,4: no dependency
        present(itype(6'h20, 5'd1, 5'd4, 16'd0), 8'h30); tick();
        present(itype(6'h10, 5'd6, 5'd5, 16'd4), 8'h31); tick();
        check("addi_nostall", bus.stall, 1'b0);
        idle(); tick();
        check("addi_valid", bus.id_ex_valid, 1'b1);
        check("addi_pc", bus.id_ex_pc, 8'h31);
        check("addi_imm", bus.id_ex_imm, 64'd4);
        check("addi_dest", bus.id_ex_dest, 5'd5);

        // ADDI r2,r0,-1
        present(itype(6'h10, 5'd0, 5'd2, 16'hFFFF), 8'h32); tick();
        idle(); tick();
        check("neg_imm", bus.id_ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("neg_dest", bus.id_ex_dest, 5'd2);
        check("neg_rs", bus.id_ex_rs_data, 64'd0);

        // ST r2,8(r1): reads rs/rt, mem_write only
        present(itype(6'h21, 5'd1, 5'd2, 16'd8), 8'h33); tick();
        idle(); tick();
        check("st_ctrl", {bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write}, 3'b001);
        check("st_rs", bus.id_ex_rs_data, 64'h99);
        check("st_rt", bus.id_ex_rt_data, 64'd7);

        // Unknown opcode: valid kept, controls and dest cleared
        present(rtype(6'h3F, 5'd1, 5'd2, 5'd9), 8'h34); tick();
        idle(); tick();
        check("unk_valid", bus.id_ex_valid, 1'b1);
        check("unk_ctrl", {bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write}, 3'b000);
        check("unk_dest", bus.id_ex_dest, 5'd0);

        // Flush during a load-use stall discards the stalled ADD
        present(itype(6'h20, 5'd1, 5'd4, 16'd0), 8'h40); tick();
        present(rtype(6'h01, 5'd4, 5'd2, 5'd5), 8'h41); tick();
        check("fl_stall_pre", bus.stall, 1'b1);
        bus.flush = 1'b1; #1;
        check("fl_stall_forced0", bus.stall, 1'b0);
        tick();
        bus.flush = 1'b0; idle(); #1;
        check("fl_idex_valid", bus.id_ex_valid, 1'b0);
        check("fl_stall_after", bus.stall, 1'b0);
        check("fl_ctrl", {bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write}, 3'b000);
        tick();
        check("fl_add_dropped", bus.id_ex_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
